mem_addr_seq: RTL and testbench

MEM_ADDR_SEQ -- requirements
Module: mem_addr_seq

---
 rtl/mem_addr_seq.sv | 160 ++++++++++++++++
 tb/tb_mem_addr_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_seq.sv
// Memory address sequencer: latches a base address, then steps through a
// burst of beats at STEP-byte increments, handshaking each beat with memory.
module mem_addr_seq #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 3,
  parameter int unsigned STEP      = 4,
  parameter int unsigned VEC_OPC   = 253,
  parameter int unsigned VEC_OVF   = 254,
  parameter int unsigned VEC_DIV   = 255,
  parameter int unsigned ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] src_pc,
  input  logic [DATA_W-1:0] src_alu,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_off;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_err;

  logic [DATA_W-1:0] w_base;
  logic              w_sel_ok;
  logic              w_misalign;
  logic              w_req_ok;
  logic              w_start_acc;
  logic              w_start_rej;
  logic              w_beat_acc;
  logic              w_last;

  localparam logic [DATA_W-1:0] P_STEP = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] P_OPC  = DATA_W'(VEC_OPC);
  localparam logic [DATA_W-1:0] P_OVF  = DATA_W'(VEC_OVF);
  localparam logic [DATA_W-1:0] P_DIV  = DATA_W'(VEC_DIV);

  // Base source mux; codes above VEC_DIV are illegal.
  always_comb begin
    w_base   = '0;
    w_sel_ok = 1'b1;
    case (sel)
      3'b000:  w_base = src_pc;
      3'b001:  w_base = src_alu;
      3'b010:  w_base = P_OPC;
      3'b011:  w_base = P_OVF;
      3'b100:  w_base = P_DIV;
      default: w_sel_ok = 1'b0;
    endcase
  end

  assign w_misalign = (ALIGN_CHK != 0) &&
                      ((w_base % P_STEP) != '0);

  assign w_req_ok = w_sel_ok &&
                    (burst_len != '0) &&
                    !w_misalign;

  assign w_start_acc = (r_state == S_IDLE) &&
                       start && w_req_ok;

  assign w_start_rej = (r_state == S_IDLE) &&
                       start && !w_req_ok;

  assign w_beat_acc = (r_state == S_BURST) &&
                      mem_ready;

  assign w_last = (r_cnt == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_next = S_BURST;
        end
      end
      S_BURST: begin
        if (w_beat_acc && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      S_BURST: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        addr_valid = 1'b0;
      end
    endcase
  end

  // Offset stops on the final beat so the idle address is the last one driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_off  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_start_rej;
      if (w_start_acc) begin
        r_base <= w_base;
        r_off  <= '0;
        r_cnt  <= burst_len;
      end else if (w_beat_acc) begin
        r_cnt <= r_cnt - LEN_W'(1);
        if (!w_last) begin
          r_off <= r_off + P_STEP;
        end
      end
    end
  end

  assign addr_out = r_base + r_off;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: queue-based beat model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_addr_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  sel = 3'd0;
  logic [31:0] src_pc = 32'd0;
  logic [31:0] src_alu = 32'd0;
  logic        start = 1'b0;
  logic [2:0]  burst_len = 3'd0;
  logic        mem_ready = 1'b0;

  logic [31:0] addr_out;
  logic        addr_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic        start2 = 1'b0;
  logic [2:0]  sel2 = 3'b100;
  logic [31:0] zero32 = 32'd0;
  logic [2:0]  len2 = 3'd1;
  logic        rdy2 = 1'b1;
  logic [31:0] a2;
  logic        v2;
  logic        b2;
  logic        d2;
  logic        e2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_addr_seq u_dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .src_pc     (src_pc),
    .src_alu    (src_alu),
    .start      (start),
    .burst_len  (burst_len),
    .mem_ready  (mem_ready),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  mem_addr_seq #(.STEP(1), .ALIGN_CHK(0)) u_vec (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel2),
    .src_pc     (zero32),
    .src_alu    (zero32),
    .start      (start2),
    .burst_len  (len2),
    .mem_ready  (rdy2),
    .addr_out   (a2),
    .addr_valid (v2),
    .busy       (b2),
    .done       (d2),
    .err        (e2)
  );

  // Model: pending beat addresses; head is the live beat.
  logic [31:0] m_q[$];
  logic [31:0] m_last = 32'd0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  bit          m_on   = 1'b0;

  function automatic void model_clear();
    m_q.delete();
    m_last = 32'd0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endfunction

  task automatic model_tick();
    bit          n_done;
    bit          n_err;
    bit          ok;
    logic [31:0] base;
    n_done = 1'b0;
    n_err  = 1'b0;
    ok     = 1'b1;
    base   = 32'd0;
    if (reset) begin
      model_clear();
    end else begin
      if (m_q.size() != 0) begin
        if (mem_ready) begin
          m_last = m_q.pop_front();
          if (m_q.size() == 0) n_done = 1'b1;
        end
      end else if (!m_done && start) begin
        case (sel)
          3'd0:    base = src_pc;
          3'd1:    base = src_alu;
          3'd2:    base = 32'd253;
          3'd3:    base = 32'd254;
          3'd4:    base = 32'd255;
          default: ok = 1'b0;
        endcase
        if (burst_len == 3'd0) ok = 1'b0;
        if ((base % 32'd4) != 32'd0) ok = 1'b0;
        if (ok) begin
          for (int k = 0; k < int'(burst_len); k++)
            m_q.push_back(base + 32'(k * 4));
        end else begin
          n_err = 1'b1;
        end
      end
      m_done = n_done;
      m_err  = n_err;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    forever begin
      @(negedge clk);
      if (m_on) begin
        exp_addr = (m_q.size() != 0) ? m_q[0] : m_last;
        chk("cyc addr_out", addr_out, exp_addr);
        chk("cyc addr_valid", 32'(addr_valid),
            32'(m_q.size() != 0));
        chk("cyc busy", 32'(busy), 32'(m_q.size() != 0));
        chk("cyc done", 32'(done), 32'(m_done));
        chk("cyc err", 32'(err), 32'(m_err));
        chk("cyc done_err_excl", 32'(done & err), 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    step();
    chk("rst addr", addr_out, 32'd0);
    chk("rst valid", 32'(addr_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    reset = 1'b0;
    m_on = 1'b1;
    step();

    // Basic 3-beat burst, start ignored in BURST and DONE
    sel = 3'd0; src_pc = 32'h100; burst_len = 3'd3;
    mem_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("b3 beat0", addr_out, 32'h100);
    chk("b3 valid0", 32'(addr_valid), 32'd1);
    sel = 3'd1; src_alu = 32'h200; start = 1'b1;
    step();
    start = 1'b0;
    chk("b3 beat1", addr_out, 32'h104);
    chk("b3 no err", 32'(err), 32'd0);
    step();
    chk("b3 beat2", addr_out, 32'h108);
    step();
    chk("b3 done", 32'(done), 32'd1);
    chk("b3 done valid", 32'(addr_valid), 32'd0);
    chk("b3 hold addr", addr_out, 32'h108);
    sel = 3'd0; src_pc = 32'h300; burst_len = 3'd1;
    start = 1'b1;
    step();
    chk("done->idle no accept", 32'(busy), 32'd0);
    chk("done->idle no pulse", 32'(done), 32'd0);
    step();
    start = 1'b0;
    chk("idle accept busy", 32'(busy), 32'd1);
    chk("idle accept addr", addr_out, 32'h300);
    step();
    step();

    // Back-pressure
    sel = 3'd1; src_alu = 32'h100; burst_len = 3'd2;
    mem_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    src_alu = 32'h500;
    chk("bp beat0", addr_out, 32'h100);
    step();
    chk("bp hold1", addr_out, 32'h100);
    step();
    chk("bp hold2", addr_out, 32'h100);
    mem_ready = 1'b1;
    step();
    chk("bp beat1", addr_out, 32'h104);
    step();
    chk("bp done", 32'(done), 32'd1);
    step();

    // Rejections
    sel = 3'b110; burst_len = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("rej sel err", 32'(err), 32'd1);
    chk("rej sel busy", 32'(busy), 32'd0);
    step();
    chk("rej err pulse", 32'(err), 32'd0);
    sel = 3'd0; src_pc = 32'h100; burst_len = 3'd0;
    start = 1'b1;
    step();
    chk("rej len0 err", 32'(err), 32'd1);
    sel = 3'd1; src_alu = 32'h102; burst_len = 3'd2;
    step();
    chk("rej align err", 32'(err), 32'd1);
    chk("rej addr hold", addr_out, 32'h104);
    sel = 3'b100;
    step();
    chk("rej vec misalign", 32'(err), 32'd1);
    start = 1'b0;
    step();

    // Wrap-around
    sel = 3'd0; src_pc = 32'hFFFF_FFFC; burst_len = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wrap beat0", addr_out, 32'hFFFF_FFFC);
    step();
    chk("wrap beat1", addr_out, 32'h0000_0000);
    chk("wrap no err", 32'(err), 32'd0);
    step();
    chk("wrap done", 32'(done), 32'd1);
    step();

    // Asynchronous reset mid-burst
    src_pc = 32'h40; burst_len = 3'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ar beat1", addr_out, 32'h44);
    #2;
    reset = 1'b1;
    #1;
    chk("ar addr", addr_out, 32'd0);
    chk("ar valid", 32'(addr_valid), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    model_clear();
    step();
    reset = 1'b0;
    step();
    chk("ar no done", 32'(done), 32'd0);
    src_pc = 32'h80; burst_len = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("ar new beat0", addr_out, 32'h80);
    step();
    chk("ar new beat1", addr_out, 32'h84);
    step();
    chk("ar new done", 32'(done), 32'd1);
    step();

    // Vector base with STEP=1, no alignment check
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("vec addr", a2, 32'd255);
    chk("vec valid", 32'(v2), 32'd1);
    chk("vec no err", 32'(e2), 32'd0);
    step();
    chk("vec done", 32'(d2), 32'd1);
    chk("vec done valid", 32'(v2), 32'd0);
    step();
    chk("vec idle", 32'(d2), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
